dcache_setassoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache. It is the next generation of the direct-mapped D-cache in the TL stage.
- Sits between the D-TLB physical address and the TLWB register. It has the same lookup, store-drain and memory-request contract as the direct-mapped cache, so the TL stage swaps it in unchanged.
- Adds these capabilities:
  - configurable ways, sets and line size;
  - per-set victim selection;
  - dirty-victim write-back sequencing;
  - refill of store-drain misses.

---
 rtl/dcache_setassoc_pkg.sv | 49 ++++
 rtl/dcache_setassoc_repl.sv | 78 +++++++
 rtl/dcache_setassoc.sv | 259 +++++++++++++++++++++++++
 tb/tb_dcache_setassoc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_setassoc_pkg.sv
// Shared types for the TL-stage data cache.
//   common              : machine-wide types (physical pointer, word, cache line,
//                         thread id) and the hardware thread count.
//   dcache_setassoc_pkg : line-level load/store helpers shared by the cache
//                         top and its sub-modules.
// No ports: packages only.

package common;
    localparam int n_threads = 4;

    typedef logic [19:0]  pptr_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] cacheline_t;
    typedef logic [1:0]   threadid_t;
endpackage

package dcache_setassoc_pkg;
    import common::*;

    // Offset width implied by the cache-line type; LINE_BYTES must agree.
    localparam int LINE_OFF_W = $clog2($bits(cacheline_t) / 8);

    // Extract the addressed word, or the zero-extended addressed byte.
    function automatic word_t load_select(cacheline_t line,
                                          logic [LINE_OFF_W-1:0] off,
                                          logic isbyte);
        word_t w;
        w = line[{off[LINE_OFF_W-1:2], 5'b00000} +: 32];
        if (isbyte) begin
            w = {24'h000000, line[{off, 3'b000} +: 8]};
        end
        return w;
    endfunction

    // Merge a word or a single byte into a line; other bytes are preserved.
    function automatic cacheline_t store_merge(cacheline_t line,
                                               logic [LINE_OFF_W-1:0] off,
                                               logic isbyte,
                                               word_t d);
        cacheline_t l;
        l = line;
        if (isbyte) begin
            l[{off, 3'b000} +: 8] = d[7:0];
        end else begin
            l[{off[LINE_OFF_W-1:2], 5'b00000} +: 32] = d;
        end
        return l;
    endfunction
endpackage

// File: rtl/dcache_setassoc_repl.sv
// dcache_repl: replacement state for one cache set.
// Build option: DCACHE_TRUE_LRU_EN selects true LRU ages; otherwise a
// round-robin pointer that advances on every fill into the set.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (state cleared to 0)
//   touch      a way of this set was accessed (hit or fill) this cycle
//   fill       a line was installed into this set this cycle
//   touch_way  the way accessed / filled
//   victim     way to replace when no invalid way exists

module dcache_repl #(
    parameter int N_WAYS = 2,
    parameter int WAY_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch,
    input  logic             fill,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim
);

`ifdef DCACHE_TRUE_LRU_EN
    localparam logic [WAY_W-1:0] MAX_AGE = WAY_W'(N_WAYS - 1);

    logic [WAY_W-1:0] age_q [N_WAYS];
    logic             unused_fill;

    assign unused_fill = fill;

    // Oldest way wins; ties resolve to the lowest-numbered way.
    always_comb begin
        logic [WAY_W-1:0] max_age;
        victim  = '0;
        max_age = age_q[0];
        for (int w = 1; w < N_WAYS; w++) begin
            if (age_q[w] > max_age) begin
                max_age = age_q[w];
                victim  = WAY_W'(w);
            end
        end
    end

    // Ways no older than the touched one age by one. Using <= rather than <
    // lets the all-zero reset state separate into distinct ages as ways are
    // touched; saturation keeps ages in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < N_WAYS; w++) begin
                age_q[w] <= '0;
            end
        end else if (touch) begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age_q[w] <= '0;
                end else if (age_q[w] <= age_q[touch_way] && age_q[w] != MAX_AGE) begin
                    age_q[w] <= age_q[w] + 1'b1;
                end
            end
        end
    end
`else
    logic [WAY_W-1:0] ptr_q;
    logic             unused_touch;

    assign unused_touch = ^{touch, touch_way};
    assign victim       = ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (fill) begin
            ptr_q <= (ptr_q == WAY_W'(N_WAYS - 1)) ? '0 : ptr_q + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/dcache_setassoc.sv
// dcache_setassoc: N-way set-associative, write-back, write-allocate D-cache
// for the TL stage. Drop-in replacement for the direct-mapped cache.
// Build option: DCACHE_TRUE_LRU_EN (true LRU instead of round-robin victims).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   thread/paddr/isvalid/flag_*/dtlb_miss   lookup request (combinational)
//   miss, data               lookup result, same cycle
//   mem_req_ren/raddr        one-cycle line refill request
//   mem_req_wen/waddr/wcacheline  one-cycle dirty victim write-back
//   mem_rec_en/addr/cacheline     returned refill line
//   stalled                  per-thread stall bits for threads waiting on a refill
//   store_en/isbyte/addr/data     store-buffer drain
//   store_busy               drain not taken this cycle
// Drain handshake: a drain is taken in the cycle store_en=1 and store_busy=0;
// with store_busy=1 the store buffer holds the same entry and retries.

module dcache_setassoc
    import common::*;
    import dcache_setassoc_pkg::*;
#(
    parameter int N_WAYS     = 2,
    parameter int N_SETS     = 4,
    parameter int LINE_BYTES = 16,
    parameter int N_THREADS  = common::n_threads
) (
    input  logic                 clk,
    input  logic                 rst,
    input  threadid_t            thread,
    input  pptr_t                paddr,
    input  logic                 isvalid,
    input  logic                 flag_mem,
    input  logic                 flag_store,
    input  logic                 flag_isbyte,
    input  logic                 dtlb_miss,
    output logic                 miss,
    output word_t                data,
    output logic                 mem_req_ren,
    output pptr_t                mem_req_raddr,
    output logic                 mem_req_wen,
    output pptr_t                mem_req_waddr,
    output cacheline_t           mem_req_wcacheline,
    input  logic                 mem_rec_en,
    input  pptr_t                mem_rec_addr,
    input  cacheline_t           mem_rec_cacheline,
    output logic [N_THREADS-1:0] stalled,
    input  logic                 store_en,
    input  logic                 store_isbyte,
    input  pptr_t                store_addr,
    input  word_t                store_data,
    output logic                 store_busy
);

    localparam int PA_W  = $bits(pptr_t);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(N_SETS);
    localparam int TAG_W = PA_W - OFF_W - IDX_W;
    localparam int WAY_W = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;

    typedef logic [TAG_W-1:0]       tag_t;
    typedef logic [IDX_W-1:0]       index_t;
    typedef logic [OFF_W-1:0]       offset_t;
    typedef logic [WAY_W-1:0]       way_t;
    typedef logic [TAG_W+IDX_W-1:0] lineaddr_t;

    typedef enum logic [1:0] {IDLE, WB, REQ, WAIT} state_t;

    // Storage
    logic [N_WAYS-1:0] valid_q [N_SETS];
    logic [N_WAYS-1:0] dirty_q [N_SETS];
    tag_t              tag_q   [N_SETS][N_WAYS];
    cacheline_t        line_q  [N_SETS][N_WAYS];

    state_t    state_q, state_d;
    lineaddr_t lat_line;
    way_t      lat_way;
    threadid_t lat_thread;
    logic      lat_stall;
    index_t    lat_idx;

    // Address split
    tag_t    lk_tag, st_tag;
    index_t  lk_idx, st_idx;
    offset_t lk_off, st_off;

    assign lk_tag  = paddr[PA_W-1 -: TAG_W];
    assign lk_idx  = paddr[OFF_W +: IDX_W];
    assign lk_off  = paddr[OFF_W-1:0];
    assign st_tag  = store_addr[PA_W-1 -: TAG_W];
    assign st_idx  = store_addr[OFF_W +: IDX_W];
    assign st_off  = store_addr[OFF_W-1:0];
    assign lat_idx = lat_line[IDX_W-1:0];

    // Tag match for the lookup port and the drain port
    logic lk_hit, st_hit;
    way_t lk_way, st_way;

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        st_hit = 1'b0;
        st_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = way_t'(w);
            end
            if (valid_q[st_idx][w] && tag_q[st_idx][w] == st_tag) begin
                st_hit = 1'b1;
                st_way = way_t'(w);
            end
        end
    end

    logic lk_active, lk_start, st_start, store_wr, fill_hit;

    assign lk_active = flag_mem & ~dtlb_miss;
    assign miss      = lk_active & (~lk_hit | (state_q != IDLE));
    assign data      = lk_hit ? load_select(line_q[lk_idx][lk_way], lk_off, flag_isbyte) : '0;

    // A lookup miss takes precedence over a drain miss in the same cycle;
    // the drain simply sees busy and retries.
    assign lk_start   = (state_q == IDLE) & lk_active & ~lk_hit;
    assign st_start   = (state_q == IDLE) & store_en & ~st_hit & ~lk_start;
    assign store_wr   = (state_q == IDLE) & store_en & st_hit;
    assign store_busy = store_en & ~store_wr;

    // Only the line bits of the returned address are compared.
    assign fill_hit = (state_q == WAIT) & mem_rec_en &
                      (mem_rec_addr[PA_W-1:OFF_W] == lat_line);

    // Victim selection for the set that is about to refill
    index_t    miss_idx;
    lineaddr_t miss_line;
    way_t      vic_way;
    logic      vic_dirty;
    way_t      repl_victim [N_SETS];

    always_comb begin
        miss_idx  = lk_start ? lk_idx : st_idx;
        miss_line = lk_start ? {lk_tag, lk_idx} : {st_tag, st_idx};
        vic_way   = repl_victim[miss_idx];
        // Descending scan so the lowest-numbered invalid way is the last one kept.
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[miss_idx][w]) begin
                vic_way = way_t'(w);
            end
        end
        vic_dirty = valid_q[miss_idx][vic_way] & dirty_q[miss_idx][vic_way];
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (lk_start || st_start) state_d = vic_dirty ? WB : REQ;
            WB:   state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: if (fill_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_wen        = (state_q == WB);
    assign mem_req_ren        = (state_q == REQ);
    assign mem_req_raddr      = {lat_line, {OFF_W{1'b0}}};
    assign mem_req_waddr      = {tag_q[lat_idx][lat_way], lat_idx, {OFF_W{1'b0}}};
    assign mem_req_wcacheline = line_q[lat_idx][lat_way];

    // Miss latch, stall bits, valid/dirty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_line   <= '0;
            lat_way    <= '0;
            lat_thread <= '0;
            lat_stall  <= 1'b0;
            stalled    <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (lk_start || st_start) begin
                lat_line   <= miss_line;
                lat_way    <= vic_way;
                lat_thread <= lk_start ? thread : '0;
                lat_stall  <= lk_start;
                if (lk_start) begin
                    stalled[thread] <= 1'b1;
                end
            end
            if (fill_hit) begin
                valid_q[lat_idx][lat_way] <= 1'b1;
                dirty_q[lat_idx][lat_way] <= 1'b0;
                if (lat_stall) begin
                    stalled[lat_thread] <= 1'b0;
                end
            end
            if (store_wr) begin
                dirty_q[st_idx][st_way] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: no reset, qualified by valid.
    always_ff @(posedge clk) begin
        if (fill_hit) begin
            tag_q[lat_idx][lat_way]  <= lat_line[TAG_W+IDX_W-1:IDX_W];
            line_q[lat_idx][lat_way] <= mem_rec_cacheline;
        end
        if (store_wr) begin
            line_q[st_idx][st_way] <= store_merge(line_q[st_idx][st_way], st_off,
                                                  store_isbyte, store_data);
        end
    end

    // Replacement: a fill wins over a same-cycle lookup hit for the touch port.
    logic [N_SETS-1:0] repl_touch, repl_fill;
    way_t              repl_way;
    logic              lk_touch;

    assign lk_touch = lk_active & lk_hit & (state_q == IDLE);
    assign repl_way = fill_hit ? lat_way : lk_way;

    always_comb begin
        for (int s = 0; s < N_SETS; s++) begin
            repl_fill[s]  = fill_hit & (lat_idx == index_t'(s));
            repl_touch[s] = fill_hit ? (lat_idx == index_t'(s))
                                     : (lk_touch & (lk_idx == index_t'(s)));
        end
    end

    for (genvar s = 0; s < N_SETS; s++) begin : g_repl
        dcache_repl #(
            .N_WAYS(N_WAYS),
            .WAY_W (WAY_W)
        ) u_repl (
            .clk      (clk),
            .rst      (rst),
            .touch    (repl_touch[s]),
            .fill     (repl_fill[s]),
            .touch_way(repl_way),
            .victim   (repl_victim[s])
        );
    end

    // Lookups are probe-only for stores; returned-line offset bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{mem_rec_addr[OFF_W-1:0], flag_store, isvalid};

endmodule

// File: tb/tb_dcache_setassoc.sv
module tb_dcache_setassoc;
    import common::*;

    logic       clk = 1'b0;
    logic       rst;
    threadid_t  thread;
    pptr_t      paddr;
    logic       isvalid, flag_mem, flag_store, flag_isbyte, dtlb_miss;
    logic       miss;
    word_t      data;
    logic       mem_req_ren, mem_req_wen;
    pptr_t      mem_req_raddr, mem_req_waddr;
    cacheline_t mem_req_wcacheline;
    logic       mem_rec_en;
    pptr_t      mem_rec_addr;
    cacheline_t mem_rec_cacheline;
    logic [3:0] stalled;
    logic       store_en, store_isbyte, store_busy;
    pptr_t      store_addr;
    word_t      store_data;

    dcache_setassoc #(.N_WAYS(2), .N_SETS(4), .LINE_BYTES(16), .N_THREADS(4)) dut (
        .clk(clk), .rst(rst), .thread(thread), .paddr(paddr), .isvalid(isvalid),
        .flag_mem(flag_mem), .flag_store(flag_store), .flag_isbyte(flag_isbyte),
        .dtlb_miss(dtlb_miss), .miss(miss), .data(data),
        .mem_req_ren(mem_req_ren), .mem_req_raddr(mem_req_raddr),
        .mem_req_wen(mem_req_wen), .mem_req_waddr(mem_req_waddr),
        .mem_req_wcacheline(mem_req_wcacheline), .mem_rec_en(mem_rec_en),
        .mem_rec_addr(mem_rec_addr), .mem_rec_cacheline(mem_rec_cacheline),
        .stalled(stalled), .store_en(store_en), .store_isbyte(store_isbyte),
        .store_addr(store_addr), .store_data(store_data), .store_busy(store_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int last_wen_cyc = -10;

    logic [37:0]  exp_lk_q[$];   // {check_data, stalled, miss, data}
    logic [20:0]  exp_ren_q[$];  // {after_writeback, raddr}
    logic [147:0] exp_wen_q[$];  // {waddr, line}
    logic [0:0]   exp_st_q[$];   // store_busy
    logic [37:0]  lk_e;
    logic [20:0]  ren_e;
    logic [147:0] wen_e;
    logic [0:0]   st_e;

    task automatic cmp(input string name, input logic [147:0] act, input logic [147:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with no expectation queued (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (isvalid) begin
                if (exp_lk_q.size() == 0) unexpected("lookup");
                else begin
                    lk_e = exp_lk_q.pop_front();
                    cmp("lookup_stalled", 148'(stalled), 148'(lk_e[36:33]));
                    cmp("lookup_miss", 148'(miss), 148'(lk_e[32]));
                    if (lk_e[37]) cmp("lookup_data", 148'(data), 148'(lk_e[31:0]));
                end
            end
            if (mem_req_wen) begin
                if (exp_wen_q.size() == 0) unexpected("writeback");
                else begin
                    wen_e = exp_wen_q.pop_front();
                    cmp("wb_addr", 148'(mem_req_waddr), 148'(wen_e[147:128]));
                    cmp("wb_line", 148'(mem_req_wcacheline), 148'(wen_e[127:0]));
                    last_wen_cyc = cyc;
                end
            end
            if (mem_req_ren) begin
                if (exp_ren_q.size() == 0) unexpected("refill");
                else begin
                    ren_e = exp_ren_q.pop_front();
                    cmp("refill_addr", 148'(mem_req_raddr), 148'(ren_e[19:0]));
                    if (ren_e[20]) cmp("wb_one_cycle_before_refill", 148'(cyc), 148'(last_wen_cyc + 1));
                end
            end
            if (store_en) begin
                if (exp_st_q.size() == 0) unexpected("store");
                else begin
                    st_e = exp_st_q.pop_front();
                    cmp("store_busy", 148'(store_busy), 148'(st_e));
                end
            end
        end
    end

    // ---------------- driver tasks (called just after a rising edge) ----------------
    function automatic cacheline_t mk_line(input word_t base);
        cacheline_t l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = base + word_t'(i);
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lookup(input threadid_t t, input pptr_t a, input logic isb, input logic fm,
                          input logic dm, input logic [3:0] exp_stl, input logic exp_miss,
                          input logic chk, input word_t exp_d);
        exp_lk_q.push_back({chk, exp_stl, exp_miss, exp_d});
        thread = t; paddr = a; isvalid = 1'b1; flag_mem = fm; dtlb_miss = dm; flag_isbyte = isb;
        step();
        isvalid = 1'b0; flag_mem = 1'b0; dtlb_miss = 1'b0; flag_isbyte = 1'b0;
    endtask

    task automatic load_hit(input threadid_t t, input pptr_t a, input logic isb, input word_t d);
        lookup(t, a, isb, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, d);
    endtask

    task automatic load_miss(input threadid_t t, input pptr_t a, input logic [3:0] stl);
        lookup(t, a, 1'b0, 1'b1, 1'b0, stl, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic store(input pptr_t a, input logic isb, input word_t d, input logic exp_busy);
        exp_st_q.push_back(exp_busy);
        store_en = 1'b1; store_addr = a; store_isbyte = isb; store_data = d;
        step();
        store_en = 1'b0;
    endtask

    task automatic fill(input pptr_t a, input cacheline_t l);
        mem_rec_en = 1'b1; mem_rec_addr = a; mem_rec_cacheline = l;
        step();
        mem_rec_en = 1'b0;
    endtask

    // Clean refill triggered by a load from thread t, no other stall pending.
    task automatic refill(input threadid_t t, input pptr_t a, input word_t base);
        exp_ren_q.push_back({1'b0, a});
        load_miss(t, a, 4'b0000);
        idle(1);
        fill(a, mk_line(base));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    cacheline_t wb_line;
    pptr_t      keep_a, evict_a;
    word_t      keep_d;

    initial begin
        rst = 1'b1; thread = '0; paddr = '0; isvalid = 0; flag_mem = 0; flag_store = 0;
        flag_isbyte = 0; dtlb_miss = 0; mem_rec_en = 0; mem_rec_addr = '0;
        mem_rec_cacheline = '0; store_en = 0; store_isbyte = 0; store_addr = '0; store_data = '0;
        idle(2);
        rst = 1'b0;
        cmp("reset_stalled", 148'(stalled), 148'(0));
        cmp("reset_ren", 148'(mem_req_ren), 148'(0));
        cmp("reset_wen", 148'(mem_req_wen), 148'(0));

        // Cold load by thread 1, busy behaviour while waiting.
        exp_ren_q.push_back({1'b0, 20'h00040});
        load_miss(1, 20'h00040, 4'b0000);
        idle(1);
        load_miss(0, 20'h00080, 4'b0010);                                // busy: miss
        lookup(0, 20'h00080, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 0);  // dtlb_miss
        lookup(0, 20'h00080, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 0);  // not mem
        fill(20'h00080, mk_line(32'hEEEE_0000));                         // wrong line
        load_miss(1, 20'h00040, 4'b0010);
        fill(20'h00040, mk_line(32'hB000_0000));
        load_hit(1, 20'h00044, 1'b0, 32'hB000_0001);
        load_hit(1, 20'h00047, 1'b1, 32'h0000_00B0);

        // Reset while waiting for a refill.
        exp_ren_q.push_back({1'b0, 20'h00080});
        load_miss(2, 20'h00080, 4'b0000);
        idle(1);
        load_miss(0, 20'h00000, 4'b0100);
        do_reset();
        cmp("rst_in_wait_stalled", 148'(stalled), 148'(0));
        fill(20'h00080, mk_line(32'hC000_0000));
        exp_ren_q.push_back({1'b0, 20'h00080});                          // IDLE again: new request
        load_miss(2, 20'h00080, 4'b0000);
        idle(1);
        fill(20'h00080, mk_line(32'hC000_0000));
        load_hit(2, 20'h00088, 1'b0, 32'hC000_0002);

        // Victim choice: A, B, touch A, then C into set 0.
        do_reset();
        refill(1, 20'h00000, 32'hA000_0000);
        refill(1, 20'h00040, 32'hB000_0000);
        load_hit(1, 20'h00000, 1'b0, 32'hA000_0000);
        refill(1, 20'h00080, 32'hC000_0000);
`ifdef DCACHE_TRUE_LRU_EN
        keep_a = 20'h00000; keep_d = 32'hA000_0000; evict_a = 20'h00040;
`else
        keep_a = 20'h00040; keep_d = 32'hB000_0000; evict_a = 20'h00000;
`endif
        load_hit(1, keep_a, 1'b0, keep_d);
        load_hit(1, 20'h00084, 1'b0, 32'hC000_0001);
        refill(1, evict_a, 32'h5000_0000);

        // Dirty eviction after a store drain.
        do_reset();
        refill(1, 20'h00100, 32'h1000_0000);
        store(20'h00100, 1'b0, 32'hDEAD_BEEF, 1'b0);
        load_hit(1, 20'h00100, 1'b0, 32'hDEAD_BEEF);
        refill(1, 20'h00140, 32'h2000_0000);
        wb_line = mk_line(32'h1000_0000);
        wb_line[31:0] = 32'hDEAD_BEEF;
        exp_wen_q.push_back({20'h00100, wb_line});
        exp_ren_q.push_back({1'b1, 20'h00180});
        load_miss(1, 20'h00180, 4'b0000);
        idle(2);
        fill(20'h00180, mk_line(32'h3000_0000));

        // Byte drain into a resident word.
        exp_ren_q.push_back({1'b0, 20'h00100});
        load_miss(1, 20'h00100, 4'b0000);
        idle(1);
        fill(20'h00100, wb_line);
        store(20'h00103, 1'b1, 32'h0000_00AB, 1'b0);
        load_hit(1, 20'h00103, 1'b1, 32'h0000_00AB);
        load_hit(1, 20'h00102, 1'b1, 32'h0000_00AD);
        load_hit(1, 20'h00100, 1'b0, 32'hABAD_BEEF);
        load_hit(1, 20'h00104, 1'b0, 32'h1000_0001);

        // Drain miss to a non-resident line.
        exp_ren_q.push_back({1'b0, 20'h00200});
        store(20'h00200, 1'b0, 32'h1234_5678, 1'b1);
        store(20'h00200, 1'b0, 32'h1234_5678, 1'b1);
        load_miss(3, 20'h00100, 4'b0000);
        fill(20'h00200, mk_line(32'h4000_0000));
        store(20'h00200, 1'b0, 32'h1234_5678, 1'b0);
        load_hit(0, 20'h00200, 1'b0, 32'h1234_5678);
        load_hit(0, 20'h00204, 1'b0, 32'h4000_0001);

        idle(3);
        while (exp_lk_q.size() != 0) begin void'(exp_lk_q.pop_front()); unexpected_left("lookup"); end
        while (exp_ren_q.size() != 0) begin void'(exp_ren_q.pop_front()); unexpected_left("refill"); end
        while (exp_wen_q.size() != 0) begin void'(exp_wen_q.pop_front()); unexpected_left("writeback"); end
        while (exp_st_q.size() != 0) begin void'(exp_st_q.pop_front()); unexpected_left("store"); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic unexpected_left(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expected DUT output never observed", name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
